lab1_imul_dot_accum: RTL and testbench

//  Downstream consumer of the integer multiplier's response stream. Sums each

---
 rtl/lab1_imul_dot_accum.sv | 102 ++++++++++
 tb/tb_lab1_imul_dot_accum.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab1_imul_dot_accum.sv
// Purpose: sums each group of NUM_TERMS multiplier products into one dot-product result.
// Latency: the result is offered the cycle after the group's last term is accepted.
// Backpressure: a held result stalls the input (in_rdy follows out_rdy while a result waits).
module lab1_imul_dot_accum #(
  parameter  int NBITS     = 32,
  parameter  int NUM_TERMS = 4,
  localparam int CW        = $clog2(NUM_TERMS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_en,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_msg,
  output logic             out_en,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_msg,
  output logic             out_ovf,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] LAST = CW'(NUM_TERMS);

  typedef enum logic {ACC, SEND} state_t;

  state_t           state, state_nx;
  logic [NBITS-1:0] acc, acc_nx;
  logic             ovf, ovf_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [NBITS:0]   sum_w;

  // One extra bit captures the carry-out of each accumulation step.
  assign sum_w = {1'b0, acc} + {1'b0, in_msg};

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    ovf_nx   = ovf;
    cnt_nx   = cnt;
    in_rdy   = 1'b0;
    out_en   = 1'b0;
    case (state)
      ACC: begin
        in_rdy = 1'b1;
        if (in_en) begin
          if (cnt == '0) begin
            acc_nx = in_msg;
            ovf_nx = 1'b0;
          end else begin
            acc_nx = sum_w[NBITS-1:0];
            ovf_nx = ovf | sum_w[NBITS];
          end
          cnt_nx = cnt + 1'b1;
          if (cnt_nx == LAST) state_nx = SEND;
        end
      end
      SEND: begin
        // Combinational ready path: a term can enter in the same cycle the result leaves.
        in_rdy = out_rdy;
        out_en = out_rdy;
        if (out_rdy) begin
          if (in_en) begin
            acc_nx   = in_msg;
            ovf_nx   = 1'b0;
            cnt_nx   = CW'(1);
            state_nx = (NUM_TERMS == 1) ? SEND : ACC;
          end else begin
            cnt_nx   = '0;
            state_nx = ACC;
          end
        end
      end
      default: state_nx = ACC;
    endcase
    // Nothing handshakes while reset is held low.
    if (!reset) begin
      in_rdy = 1'b0;
      out_en = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ACC;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      ovf   <= ovf_nx;
      cnt   <= cnt_nx;
    end
  end

  // Visible outputs read as zero while reset is low, even before the first edge.
  assign out_msg = reset ? acc : '0;
  assign out_ovf = reset ? ovf : 1'b0;
  assign count   = reset ? cnt : '0;

endmodule

// File: tb/tb_lab1_imul_dot_accum.sv
// Bench for lab1_imul_dot_accum: a 4-term and a 1-term instance checked against a
// group-sum scoreboard every cycle, plus hand-computed literal expectations.
module tb_lab1_imul_dot_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_en   [2];
  logic        in_rdy  [2];
  logic [31:0] in_msg  [2];
  logic        out_en  [2];
  logic        out_rdy [2];
  logic [31:0] out_msg [2];
  logic        out_ovf [2];
  logic [2:0]  count4;
  logic [0:0]  count1;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lab1_imul_dot_accum #(.NBITS(32), .NUM_TERMS(4)) dut4 (
    .clk(clk), .reset(reset),
    .in_en(in_en[0]), .in_rdy(in_rdy[0]), .in_msg(in_msg[0]),
    .out_en(out_en[0]), .out_rdy(out_rdy[0]), .out_msg(out_msg[0]),
    .out_ovf(out_ovf[0]), .count(count4)
  );

  lab1_imul_dot_accum #(.NBITS(32), .NUM_TERMS(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_en(in_en[1]), .in_rdy(in_rdy[1]), .in_msg(in_msg[1]),
    .out_en(out_en[1]), .out_rdy(out_rdy[1]), .out_msg(out_msg[1]),
    .out_ovf(out_ovf[1]), .count(count1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard model ----------------
  // A group is a list of accepted terms; its result is the true sum reduced mod 2^32,
  // with ovf set when the true sum reached 2^32. A finished group waits for the sink.
  int          m_cnt  [2];
  bit          m_pend [2];
  logic [63:0] m_sum  [2];
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  task automatic model_step(input int k, input int n, input int cnt_act);
    logic [32:0] exp_r;
    logic        exp_rdy;
    logic        send, take;
    exp_rdy = !m_pend[k] || out_rdy[k];
    if (!reset) begin
      chk($sformatf("i%0d_rst_in_rdy", k), 64'(in_rdy[k]), 64'd0);
      chk($sformatf("i%0d_rst_out_en", k), 64'(out_en[k]), 64'd0);
      chk($sformatf("i%0d_rst_out_msg", k), 64'(out_msg[k]), 64'd0);
      chk($sformatf("i%0d_rst_out_ovf", k), 64'(out_ovf[k]), 64'd0);
      chk($sformatf("i%0d_rst_count", k), 64'(cnt_act), 64'd0);
      m_cnt[k]  = 0;
      m_pend[k] = 1'b0;
      m_sum[k]  = '0;
      if (k == 0) q0.delete(); else q1.delete();
    end else begin
      chk($sformatf("i%0d_in_rdy", k), 64'(in_rdy[k]), 64'(exp_rdy));
      chk($sformatf("i%0d_out_en", k), 64'(out_en[k]), 64'(m_pend[k] && out_rdy[k]));
      chk($sformatf("i%0d_count", k), 64'(cnt_act), 64'(m_cnt[k]));
      if (!exp_rdy) chk($sformatf("i%0d_protocol_in_en", k), 64'(in_en[k]), 64'd0);
      send = m_pend[k] && out_rdy[k];
      take = in_en[k] && exp_rdy;
      if (send && out_en[k]) begin
        exp_r = 'x;
        if (k == 0 && q0.size() > 0) exp_r = q0.pop_front();
        if (k == 1 && q1.size() > 0) exp_r = q1.pop_front();
        chk($sformatf("i%0d_out_msg", k), 64'(out_msg[k]), 64'(exp_r[31:0]));
        chk($sformatf("i%0d_out_ovf", k), 64'(out_ovf[k]), 64'(exp_r[32]));
      end
      if (send) begin
        m_pend[k] = 1'b0;
        m_cnt[k]  = 0;
      end
      if (take) begin
        m_sum[k] = (m_cnt[k] == 0) ? {32'd0, in_msg[k]} : m_sum[k] + {32'd0, in_msg[k]};
        m_cnt[k]++;
        if (m_cnt[k] == n) begin
          m_pend[k] = 1'b1;
          exp_r = {m_sum[k] >= 64'h1_0000_0000, m_sum[k][31:0]};
          if (k == 0) q0.push_back(exp_r); else q1.push_back(exp_r);
        end
      end
    end
  endtask

  // Compare process: mid-cycle, check outputs, then advance the model for the coming edge.
  always @(negedge clk) begin
    model_step(0, 4, int'(count4));
    model_step(1, 1, int'(count1));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic group4(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
    logic [31:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      in_en[0]  = 1'b1;
      in_msg[0] = v[i];
      cyc();
    end
    in_en[0] = 1'b0;
  endtask

  task automatic lit_out(input string name, input logic [31:0] msg, input logic ovf);
    chk({name, "_out_en"}, 64'(out_en[0]), 64'd1);
    chk({name, "_out_msg"}, 64'(out_msg[0]), 64'(msg));
    chk({name, "_out_ovf"}, 64'(out_ovf[0]), 64'(ovf));
  endtask

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_en[k] = 1'b0; in_msg[k] = '0; out_rdy[k] = 1'b1;
    end
    repeat (2) cyc();
    chk("reset_in_rdy", 64'(in_rdy[0]), 64'd0);
    chk("reset_count", 64'(count4), 64'd0);
    reset = 1'b1;
    #1;
    chk("release_in_rdy", 64'(in_rdy[0]), 64'd1);

    // 1: 1,2,3,4 -> 10, count steps 1..4, single result cycle
    for (int i = 1; i <= 4; i++) begin
      in_en[0] = 1'b1; in_msg[0] = 32'(i);
      cyc();
      chk($sformatf("t1_count_%0d", i), 64'(count4), 64'(i));
    end
    in_en[0] = 1'b0;
    lit_out("t1", 32'd10, 1'b0);
    cyc();
    chk("t1_single_pulse", 64'(out_en[0]), 64'd0);
    chk("t1_count_cleared", 64'(count4), 64'd0);

    // 2: carry-out, then ovf cleared on the next group
    group4(32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
    lit_out("t2a", 32'd1, 1'b1);
    group4(32'd5, 32'd5, 32'd5, 32'd5);
    lit_out("t2b", 32'd20, 1'b0);
    cyc();

    // 3: backpressure holds the result and stalls input
    out_rdy[0] = 1'b0;
    group4(32'd7, 32'd0, 32'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_in_rdy", 64'(in_rdy[0]), 64'd0);
      chk("t3_out_en", 64'(out_en[0]), 64'd0);
      chk("t3_count", 64'(count4), 64'd4);
      chk("t3_held_msg", 64'(out_msg[0]), 64'd8);
      cyc();
    end
    out_rdy[0] = 1'b1;
    #1;
    lit_out("t3", 32'd8, 1'b0);
    cyc();
    chk("t3_single_pulse", 64'(out_en[0]), 64'd0);

    // 4: overlap the first term of a group with the outgoing result
    group4(32'd1, 32'd1, 32'd1, 32'd1);
    in_en[0] = 1'b1; in_msg[0] = 32'd9;
    lit_out("t4a", 32'd4, 1'b0);
    cyc();
    chk("t4_count_after_overlap", 64'(count4), 64'd1);
    chk("t4_acc_after_overlap", 64'(out_msg[0]), 64'd9);
    for (int i = 0; i < 3; i++) begin
      in_en[0] = 1'b1; in_msg[0] = 32'd1;
      cyc();
    end
    in_en[0] = 1'b0;
    lit_out("t4b", 32'd12, 1'b0);
    group4(32'd2, 32'd2, 32'd2, 32'd2);
    lit_out("t4c", 32'd8, 1'b0);
    group4(32'd3, 32'd3, 32'd3, 32'd3);
    lit_out("t4d", 32'd12, 1'b0);
    cyc();

    // 5: reset mid-group, then reset while a result is held
    for (int i = 0; i < 2; i++) begin
      in_en[0] = 1'b1; in_msg[0] = 32'd5;
      cyc();
    end
    in_en[0] = 1'b0;
    reset = 1'b0;
    cyc();
    chk("t5a_in_rdy", 64'(in_rdy[0]), 64'd0);
    chk("t5a_out_en", 64'(out_en[0]), 64'd0);
    chk("t5a_count", 64'(count4), 64'd0);
    reset = 1'b1;
    #1;
    chk("t5a_release_in_rdy", 64'(in_rdy[0]), 64'd1);
    chk("t5a_release_count", 64'(count4), 64'd0);
    out_rdy[0] = 1'b0;
    group4(32'd1, 32'd2, 32'd3, 32'd4);
    cyc();
    reset = 1'b0;
    cyc();
    chk("t5b_in_rdy", 64'(in_rdy[0]), 64'd0);
    chk("t5b_out_en", 64'(out_en[0]), 64'd0);
    out_rdy[0] = 1'b1;
    reset = 1'b1;
    #1;
    chk("t5b_release_count", 64'(count4), 64'd0);
    chk("t5b_release_out_en", 64'(out_en[0]), 64'd0);
    group4(32'd1, 32'd1, 32'd1, 32'd1);
    lit_out("t5", 32'd4, 1'b0);
    cyc();

    // 6: single-term groups stream one result per cycle
    for (int i = 1; i <= 3; i++) begin
      in_en[1] = 1'b1; in_msg[1] = 32'(3 * i);
      cyc();
      chk($sformatf("t6_out_en_%0d", i), 64'(out_en[1]), 64'd1);
      chk($sformatf("t6_out_msg_%0d", i), 64'(out_msg[1]), 64'(3 * i));
    end
    in_en[1] = 1'b0;
    cyc();
    chk("t6_drained", 64'(out_en[1]), 64'd0);

    // Random sink readiness and sender activity on both instances
    repeat (300) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) out_rdy[k] = 1'($urandom_range(0, 1));
      #1;
      for (int k = 0; k < 2; k++) begin
        in_en[k]  = ($urandom_range(0, 3) != 0) && in_rdy[k];
        in_msg[k] = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 1000));
      end
    end
    for (int k = 0; k < 2; k++) begin
      in_en[k] = 1'b0; out_rdy[k] = 1'b1;
    end
    repeat (3) cyc();
    chk("final_q0_empty", 64'(q0.size()), 64'd0);
    chk("final_q1_empty", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
